// File: rtl/sha256_pkg.sv
// Shared constants, scheme encodings and assembler state type for the SHA-256 engine.
package sha256_pkg;
   localparam int SHA_BLK_W = 512;
   localparam int SHA_LEN_W = 64;

   localparam logic [1:0] SCHEME_PAD = 2'b00;
   localparam logic [1:0] SCHEME_RAW = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      FILL,
      PAD,
      LENBLK,
      EMIT
   } asm_state_t;
endpackage

// File: rtl/sha256_block_assembler_if.sv
// Word-in / config / block-out handshake bundle around the block assembler.
// master: the upstream FIFOs and downstream compressor; slave: the assembler.
interface sha256_block_assembler_if
   import sha256_pkg::*;
#(
   parameter int DATA_W = 32
);
   logic [DATA_W-1:0]    data_in;
   logic                 data_in_last;
   logic                 data_in_valid;
   logic                 data_in_ready;
   logic [SHA_LEN_W-1:0] cfg_size;
   logic [1:0]           cfg_scheme;
   logic                 cfg_valid;
   logic                 cfg_ready;
   logic [SHA_BLK_W-1:0] data_out;
   logic                 data_out_last;
   logic                 data_out_valid;
   logic                 data_out_ready;

   modport master (
      output data_in, data_in_last, data_in_valid,
      output cfg_size, cfg_scheme, cfg_valid,
      output data_out_ready,
      input  data_in_ready, cfg_ready,
      input  data_out, data_out_last, data_out_valid
   );

   modport slave (
      input  data_in, data_in_last, data_in_valid,
      input  cfg_size, cfg_scheme, cfg_valid,
      input  data_out_ready,
      output data_in_ready, cfg_ready,
      output data_out, data_out_last, data_out_valid
   );
endinterface

// File: rtl/sha256_pad_gen.sv
// Purely combinational: sets the 0x80 marker bit at message position p and,
// when the 64-bit length still fits behind it, writes the length into bits [63:0].
module sha256_pad_gen
   import sha256_pkg::*;
(
   input  logic [SHA_BLK_W-1:0] blk_in,
   input  logic [8:0]           p,
   input  logic [SHA_LEN_W-1:0] size,
   output logic [SHA_BLK_W-1:0] blk_out,
   output logic                 fits
);
   logic [SHA_BLK_W-1:0] marker;

   assign fits   = (p <= 9'd447);
   assign marker = {1'b1, {(SHA_BLK_W-1){1'b0}}} >> p;

   always_comb begin
      blk_out = blk_in | marker;
      if (fits) begin
         blk_out[SHA_LEN_W-1:0] = size;
      end
   end
endmodule

// File: rtl/sha256_block_assembler.sv
// Packs DATA_W-bit message words into 512-bit blocks with SHA-256 padding or raw pass-through.
// One word per cycle in FILL; input stalls while the single block buffer waits in EMIT.
module sha256_block_assembler
   import sha256_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     en,
   input  logic                     sync_rst,
   sha256_block_assembler_if.slave  bus,
   output logic                     err
);
   localparam int WPB    = SHA_BLK_W / DATA_W;
   localparam int LOG_DW = $clog2(DATA_W);

   generate
      if (DATA_W != 32 && DATA_W != 64 && DATA_W != 128 && DATA_W != 256 && DATA_W != 512) begin : g_bad_width
         $error("sha256_block_assembler: DATA_W must be 32, 64, 128, 256 or 512");
      end
   endgenerate

   asm_state_t           state, state_n, nxt_q, nxt_n;
   logic [SHA_BLK_W-1:0] blk, blk_n;
   logic [63:0]          count, count_n;
   logic [63:0]          nwords_q, nwords_n;
   logic [SHA_LEN_W-1:0] size_q, size_n;
   logic                 raw_q, raw_n;
   logic                 last_q, last_n;
   logic                 err_q, err_n;

   logic [63:0]          cfg_nwords;
   logic [3:0]           slot;
   logic                 is_final;
   logic                 blk_full;
   logic [LOG_DW-1:0]    tail_bits;
   logic [DATA_W-1:0]    word_mask;
   logic [DATA_W-1:0]    word_m;
   logic [9:0]           shamt;
   logic [SHA_BLK_W-1:0] word_placed;
   logic [SHA_BLK_W-1:0] pad_blk;
   logic                 pad_fits;

   // ceil(size/DATA_W) without the overflow of adding DATA_W-1 first
   assign cfg_nwords = (bus.cfg_size >> LOG_DW) + {63'd0, |bus.cfg_size[LOG_DW-1:0]};

   assign slot     = count[3:0] & 4'(WPB - 1);
   assign is_final = (count == nwords_q - 64'd1);
   assign blk_full = (slot == 4'(WPB - 1));

   // Only the final word can be partial; its bits past the message end are dropped.
   assign tail_bits   = size_q[LOG_DW-1:0];
   assign word_mask   = (is_final && tail_bits != '0) ? ~({DATA_W{1'b1}} >> tail_bits)
                                                       : {DATA_W{1'b1}};
   assign word_m      = bus.data_in & word_mask;
   assign shamt       = 10'((WPB - 1 - int'(slot)) * DATA_W);
   assign word_placed = SHA_BLK_W'(word_m) << shamt;

   sha256_pad_gen u_pad_gen (
      .blk_in  (blk),
      .p       (size_q[8:0]),
      .size    (size_q),
      .blk_out (pad_blk),
      .fits    (pad_fits)
   );

   assign bus.cfg_ready      = en & (state == IDLE);
   assign bus.data_in_ready  = en & (state == FILL);
   assign bus.data_out_valid = (state == EMIT);
   assign bus.data_out_last  = last_q & (state == EMIT);
   assign bus.data_out       = blk;
   assign err                = err_q;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         nxt_q    <= IDLE;
         blk      <= '0;
         count    <= '0;
         nwords_q <= '0;
         size_q   <= '0;
         raw_q    <= 1'b0;
         last_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state    <= state_n;
         nxt_q    <= nxt_n;
         blk      <= blk_n;
         count    <= count_n;
         nwords_q <= nwords_n;
         size_q   <= size_n;
         raw_q    <= raw_n;
         last_q   <= last_n;
         err_q    <= err_n;
      end
   end

   always_comb begin
      state_n  = state;
      nxt_n    = nxt_q;
      blk_n    = blk;
      count_n  = count;
      nwords_n = nwords_q;
      size_n   = size_q;
      raw_n    = raw_q;
      last_n   = last_q;
      err_n    = err_q;

      if (sync_rst) begin
         state_n  = IDLE;
         nxt_n    = IDLE;
         blk_n    = '0;
         count_n  = '0;
         nwords_n = '0;
         size_n   = '0;
         raw_n    = 1'b0;
         last_n   = 1'b0;
         err_n    = 1'b0;
      end else if (en) begin
         unique case (state)
            IDLE: begin
               if (bus.cfg_valid) begin
                  size_n   = bus.cfg_size;
                  raw_n    = (bus.cfg_scheme == SCHEME_RAW);
                  nwords_n = cfg_nwords;
                  blk_n    = '0;
                  count_n  = '0;
                  last_n   = 1'b0;
                  if (bus.cfg_scheme != SCHEME_PAD && bus.cfg_scheme != SCHEME_RAW) begin
                     err_n = 1'b1;
                  end
                  if (cfg_nwords != 64'd0) begin
                     state_n = FILL;
                  end else if (bus.cfg_scheme == SCHEME_RAW) begin
                     err_n   = 1'b1;
                     state_n = IDLE;
                  end else begin
                     state_n = PAD;
                  end
               end
            end
            FILL: begin
               if (bus.data_in_valid) begin
                  blk_n   = blk | word_placed;
                  count_n = count + 64'd1;
                  // data_in_last is only cross-checked; the configured size decides framing
                  if (bus.data_in_last != is_final) begin
                     err_n = 1'b1;
                  end
                  if (is_final) begin
                     if (raw_q) begin
                        state_n = EMIT;
                        last_n  = 1'b1;
                        if (size_q[8:0] != 9'd0) begin
                           err_n = 1'b1;
                        end
                     end else if (size_q[8:0] != 9'd0) begin
                        state_n = PAD;
                     end else begin
                        state_n = EMIT;
                        last_n  = 1'b0;
                        nxt_n   = PAD;
                     end
                  end else if (blk_full) begin
                     state_n = EMIT;
                     last_n  = 1'b0;
                     nxt_n   = FILL;
                  end
               end
            end
            PAD: begin
               blk_n   = pad_blk;
               state_n = EMIT;
               if (pad_fits) begin
                  last_n = 1'b1;
               end else begin
                  last_n = 1'b0;
                  nxt_n  = LENBLK;
               end
            end
            LENBLK: begin
               blk_n   = {{(SHA_BLK_W-SHA_LEN_W){1'b0}}, size_q};
               last_n  = 1'b1;
               state_n = EMIT;
            end
            EMIT: begin
               if (bus.data_out_ready) begin
                  blk_n   = '0;
                  state_n = last_q ? IDLE : nxt_q;
                  last_n  = 1'b0;
               end
            end
            default: state_n = IDLE;
         endcase
      end
   end
endmodule
